// File: rtl/tmds_encoder_multi_if.sv
// Parallel-side bundle of the multi-lane TMDS encoder: period type and per-lane
// payload in, encoded 10-bit symbols and status out.
interface tmds_encoder_multi_if #(
    parameter int CHANNELS = 3
);
    logic [2:0]            MODE_I;
    logic [8*CHANNELS-1:0] VID_I;
    logic [2*CHANNELS-1:0] CTL_I;
    logic [4*CHANNELS-1:0] AUX_I;
    logic [10*CHANNELS-1:0] TMDS_O;
    logic [2:0]            MODE_O;
    logic                  ERR_O;

    modport master (
        output MODE_I, VID_I, CTL_I, AUX_I,
        input  TMDS_O, MODE_O, ERR_O
    );

    modport slave (
        input  MODE_I, VID_I, CTL_I, AUX_I,
        output TMDS_O, MODE_O, ERR_O
    );
endinterface

// File: rtl/tmds_encoder_multi.sv
// Multi-mode HDMI TMDS encoder: CHANNELS independent lanes, each with its own
// running-disparity counter, 2-stage pipeline (transition minimise, then DC balance).
module tmds_encoder_multi #(
    parameter int CHANNELS    = 3,
    parameter bit BIT_REVERSE = 1'b0
) (
    input  logic                 PXLCLK_I,
    input  logic                 RST_I,
    tmds_encoder_multi_if.slave  bus
);
    localparam int DATA_W = 8;

    localparam logic [2:0] MODE_CTRL        = 3'd0;
    localparam logic [2:0] MODE_VIDEO       = 3'd1;
    localparam logic [2:0] MODE_VID_GB      = 3'd2;
    localparam logic [2:0] MODE_DAT_GB      = 3'd3;
    localparam logic [2:0] MODE_DATA_ISLAND = 3'd4;

    localparam logic [9:0] SYM_CTRL_00  = 10'b1101010100;
    localparam logic [9:0] SYM_GB_BR    = 10'b1011001100;
    localparam logic [9:0] SYM_GB_GREEN = 10'b0100110011;

    function automatic logic [9:0] ctrl_sym(input logic [1:0] ctl);
        case (ctl)
            2'b00:   ctrl_sym = 10'b1101010100;
            2'b01:   ctrl_sym = 10'b0010101011;
            2'b10:   ctrl_sym = 10'b0101010100;
            default: ctrl_sym = 10'b1010101011;
        endcase
    endfunction

    function automatic logic [9:0] terc4_sym(input logic [3:0] d);
        case (d)
            4'd0:    terc4_sym = 10'b1010011100;
            4'd1:    terc4_sym = 10'b1001100011;
            4'd2:    terc4_sym = 10'b1011100100;
            4'd3:    terc4_sym = 10'b1011100010;
            4'd4:    terc4_sym = 10'b0101110001;
            4'd5:    terc4_sym = 10'b0100011110;
            4'd6:    terc4_sym = 10'b0110001110;
            4'd7:    terc4_sym = 10'b0100111100;
            4'd8:    terc4_sym = 10'b1011001100;
            4'd9:    terc4_sym = 10'b0100111001;
            4'd10:   terc4_sym = 10'b0110011100;
            4'd11:   terc4_sym = 10'b1011000110;
            4'd12:   terc4_sym = 10'b1010001110;
            4'd13:   terc4_sym = 10'b1001110001;
            4'd14:   terc4_sym = 10'b0101100011;
            default: terc4_sym = 10'b1011000011;
        endcase
    endfunction

    function automatic logic [3:0] ones8(input logic [DATA_W-1:0] d);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < DATA_W; i++) n = n + {3'b000, d[i]};
        return n;
    endfunction

    // Transition-minimised word; bit 8 set means the XOR chain was used.
    function automatic logic [8:0] qm_encode(input logic [DATA_W-1:0] d);
        logic [3:0] n;
        logic       use_xnor;
        logic [8:0] q;
        n        = ones8(d);
        use_xnor = (n > 4'd4) || ((n == 4'd4) && !d[0]);
        q        = '0;
        q[0]     = d[0];
        for (int i = 1; i < DATA_W; i++)
            q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        q[8] = ~use_xnor;
        return q;
    endfunction

    function automatic logic [9:0] mirror10(input logic [9:0] s);
        logic [9:0] m;
        for (int i = 0; i < 10; i++) m[i] = s[9-i];
        return m;
    endfunction

    logic [2:0]                mode_p1;
    logic [2:0]                mode_p2;
    logic                      err_p2;
    logic [10*CHANNELS-1:0]    tmds_flat;

    // ---- stage 1: input capture, q_m and its ones count ----
    always_ff @(posedge PXLCLK_I) begin
        if (RST_I) mode_p1 <= MODE_CTRL;
        else       mode_p1 <= bus.MODE_I;
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        localparam int ROLE = c % 3;

        logic [1:0]        ctl_p1;
        logic [3:0]        aux_p1;
        logic [8:0]        qm_p1;
        logic [3:0]        n1_p1;
        logic [8:0]        qm_in;
        logic signed [4:0] cnt_p2;
        logic [9:0]        sym_p2;
        logic signed [4:0] cnt_nxt;
        logic [9:0]        sym_nxt;
        logic signed [5:0] diff;
        logic signed [5:0] cnt_ext;
        logic signed [5:0] cnt_sum;
        logic              qm8;

        assign qm_in = qm_encode(bus.VID_I[DATA_W*c +: DATA_W]);

        always_ff @(posedge PXLCLK_I) begin
            if (RST_I) ctl_p1 <= 2'b00;
            else       ctl_p1 <= bus.CTL_I[2*c +: 2];
        end

        always_ff @(posedge PXLCLK_I) begin
            aux_p1 <= bus.AUX_I[4*c +: 4];
            qm_p1  <= qm_in;
            n1_p1  <= ones8(qm_in[7:0]);
        end

        // ---- stage 2: mode select and DC balancing ----
        always_comb begin
            qm8     = qm_p1[8];
            diff    = $signed({1'b0, n1_p1, 1'b0}) - 6'sd8;
            cnt_ext = {cnt_p2[4], cnt_p2};
            cnt_sum = '0;
            sym_nxt = ctrl_sym(ctl_p1);
            case (mode_p1)
                MODE_VIDEO: begin
                    if ((cnt_p2 == 5'sd0) || (n1_p1 == 4'd4)) begin
                        sym_nxt = {~qm8, qm8, qm8 ? qm_p1[7:0] : ~qm_p1[7:0]};
                        cnt_sum = qm8 ? (cnt_ext + diff) : (cnt_ext - diff);
                    end else if (((cnt_p2 > 5'sd0) && (n1_p1 > 4'd4)) ||
                                 ((cnt_p2 < 5'sd0) && (n1_p1 < 4'd4))) begin
                        sym_nxt = {1'b1, qm8, ~qm_p1[7:0]};
                        cnt_sum = cnt_ext + (qm8 ? 6'sd2 : 6'sd0) - diff;
                    end else begin
                        sym_nxt = {1'b0, qm8, qm_p1[7:0]};
                        cnt_sum = cnt_ext - (qm8 ? 6'sd0 : 6'sd2) + diff;
                    end
                end
                MODE_VID_GB:      sym_nxt = (ROLE == 1) ? SYM_GB_GREEN : SYM_GB_BR;
                MODE_DAT_GB:      sym_nxt = (ROLE == 0) ? terc4_sym({2'b11, ctl_p1}) : SYM_GB_GREEN;
                MODE_DATA_ISLAND: sym_nxt = terc4_sym(aux_p1);
                default:          sym_nxt = ctrl_sym(ctl_p1);
            endcase
            // Every non-video symbol restarts the balance from zero.
            cnt_nxt = cnt_sum[4:0];
        end

        always_ff @(posedge PXLCLK_I) begin
            if (RST_I) begin
                cnt_p2 <= 5'sd0;
                sym_p2 <= SYM_CTRL_00;
            end else begin
                cnt_p2 <= cnt_nxt;
                sym_p2 <= sym_nxt;
            end
        end

        assign tmds_flat[10*c +: 10] = BIT_REVERSE ? mirror10(sym_p2) : sym_p2;
    end

    always_ff @(posedge PXLCLK_I) begin
        if (RST_I) begin
            mode_p2 <= MODE_CTRL;
            err_p2  <= 1'b0;
        end else begin
            mode_p2 <= mode_p1;
            if (mode_p1 > MODE_DATA_ISLAND) err_p2 <= 1'b1;
        end
    end

    assign bus.TMDS_O = tmds_flat;
    assign bus.MODE_O = mode_p2;
    assign bus.ERR_O  = err_p2;
endmodule

// File: tb/tb_tmds_encoder_multi.sv
// Randomised bench for tmds_encoder_multi against a spec-level reference model
// (per-lane disparity bookkeeping, code tables, 2-cycle alignment).
module tb_tmds_encoder_multi;
    localparam int CH = 4;

    localparam logic [9:0] CTRL_TAB [4] = '{10'b1101010100, 10'b0010101011,
                                            10'b0101010100, 10'b1010101011};
    localparam logic [9:0] TERC4_TAB [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tmds_encoder_multi_if #(.CHANNELS(CH)) bus();

    tmds_encoder_multi #(.CHANNELS(CH), .BIT_REVERSE(1'b0)) dut (
        .PXLCLK_I (clk),
        .RST_I    (rst),
        .bus      (bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Model of what sits in stage 1, plus the per-lane balance counters.
    logic [2:0] m_mode = 3'd0;
    logic [7:0] m_vid [CH];
    logic [1:0] m_ctl [CH];
    logic [3:0] m_aux [CH];
    int         m_cnt [CH];
    logic [2:0] m_mode_o = 3'd0;
    logic       m_err = 1'b0;
    int         disp [CH];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] ref_video(input logic [7:0] d, inout int cnt);
        int n1d, n1, n0, b8;
        bit use_xnor;
        logic [8:0] q;
        logic [9:0] s;
        n1d = $countones(d);
        use_xnor = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
        q = '0;
        q[0] = d[0];
        for (int i = 1; i < 8; i++) q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        q[8] = !use_xnor;
        b8 = q[8] ? 1 : 0;
        n1 = $countones(q[7:0]);
        n0 = 8 - n1;
        if (cnt == 0 || n1 == n0) begin
            s = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
            cnt = cnt + (b8 == 1 ? (n1 - n0) : (n0 - n1));
        end else if ((cnt > 0 && n1 > n0) || (cnt < 0 && n0 > n1)) begin
            s = {1'b1, q[8], ~q[7:0]};
            cnt = cnt + 2 * b8 + n0 - n1;
        end else begin
            s = {1'b0, q[8], q[7:0]};
            cnt = cnt - 2 * (1 - b8) + n1 - n0;
        end
        return s;
    endfunction

    function automatic logic [7:0] tmds_decode(input logic [9:0] s);
        logic [7:0] d8, o;
        d8 = s[9] ? ~s[7:0] : s[7:0];
        o[0] = d8[0];
        for (int i = 1; i < 8; i++) o[i] = s[8] ? (d8[i] ^ d8[i-1]) : ~(d8[i] ^ d8[i-1]);
        return o;
    endfunction

    // One pixel clock: drive inputs, advance the model, compare all outputs.
    task automatic step(input bit r, input logic [2:0] mode, input logic [8*CH-1:0] vid,
                        input logic [2*CH-1:0] ctl, input logic [4*CH-1:0] aux);
        logic [10*CH-1:0] exp_tmds;
        logic [9:0] s;
        @(negedge clk);
        rst = r;
        bus.MODE_I = mode;
        bus.VID_I  = vid;
        bus.CTL_I  = ctl;
        bus.AUX_I  = aux;
        @(posedge clk);
        #1;
        exp_tmds = '0;
        if (r) begin
            for (int c = 0; c < CH; c++) begin
                exp_tmds[10*c +: 10] = CTRL_TAB[0];
                m_cnt[c] = 0;
                m_ctl[c] = 2'b00;
            end
            m_mode = 3'd0;
            m_mode_o = 3'd0;
            m_err = 1'b0;
        end else begin
            for (int c = 0; c < CH; c++) begin
                case (m_mode)
                    3'd1: s = ref_video(m_vid[c], m_cnt[c]);
                    3'd2: s = (c % 3 == 1) ? 10'b0100110011 : 10'b1011001100;
                    3'd3: s = (c % 3 == 0) ? TERC4_TAB[{2'b11, m_ctl[c]}] : 10'b0100110011;
                    3'd4: s = TERC4_TAB[m_aux[c]];
                    default: s = CTRL_TAB[m_ctl[c]];
                endcase
                if (m_mode != 3'd1) m_cnt[c] = 0;
                exp_tmds[10*c +: 10] = s;
                if (m_mode == 3'd1)
                    chk("decode", 64'(tmds_decode(bus.TMDS_O[10*c +: 10])), 64'(m_vid[c]));
            end
            m_mode_o = m_mode;
            if (m_mode > 3'd4) m_err = 1'b1;
            m_mode = mode;
            for (int c = 0; c < CH; c++) begin
                m_vid[c] = vid[8*c +: 8];
                m_ctl[c] = ctl[2*c +: 2];
                m_aux[c] = aux[4*c +: 4];
            end
        end
        chk("tmds", 64'(bus.TMDS_O), 64'(exp_tmds));
        chk("mode_o", 64'(bus.MODE_O), 64'(m_mode_o));
        chk("err", 64'(bus.ERR_O), 64'(m_err));
        for (int c = 0; c < CH; c++) begin
            if (m_mode_o == 3'd1) begin
                disp[c] += 2 * $countones(bus.TMDS_O[10*c +: 10]) - 10;
                chk("disp_bound", 64'(disp[c] <= 10 && disp[c] >= -10), 64'd1);
            end else begin
                disp[c] = 0;
            end
        end
    endtask

    task automatic step_rand(input logic [2:0] mode);
        step(1'b0, mode, $urandom, 8'($urandom), 16'($urandom));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int c = 0; c < CH; c++) disp[c] = 0;
        bus.MODE_I = 3'd0;
        bus.VID_I  = '0;
        bus.CTL_I  = '0;
        bus.AUX_I  = '0;

        // Reset state
        for (int i = 0; i < 3; i++) step(1'b1, 3'd1, $urandom, 8'($urandom), 16'($urandom));
        chk("rst_lane0", 64'(bus.TMDS_O[9:0]), 64'(10'b1101010100));
        chk("rst_mode", 64'(bus.MODE_O), 64'd0);
        chk("rst_err", 64'(bus.ERR_O), 64'd0);

        // CTRL sweep on lane 0, then a video byte from zero disparity
        for (int k = 0; k < 4; k++) step(1'b0, 3'd0, '0, 8'(k), '0);
        step_rand(3'd1);
        chk("ctrl_11", 64'(bus.TMDS_O[9:0]), 64'(10'b1010101011));
        step(1'b0, 3'd0, '0, '0, '0);

        // Constant 0x00 video: 0100000000, 1111111111, 0100000000
        step(1'b0, 3'd1, '0, '0, '0);
        step(1'b0, 3'd1, '0, '0, '0);
        chk("v00_sym0", 64'(bus.TMDS_O[9:0]), 64'(10'b0100000000));
        step(1'b0, 3'd1, '0, '0, '0);
        chk("v00_sym1", 64'(bus.TMDS_O[9:0]), 64'(10'b1111111111));
        step(1'b0, 3'd1, '0, '0, '0);
        chk("v00_sym2", 64'(bus.TMDS_O[9:0]), 64'(10'b0100000000));

        // Data island period framing
        for (int i = 0; i < 8; i++) step_rand(3'd0);
        for (int i = 0; i < 2; i++) step_rand(3'd3);
        for (int k = 0; k < 16; k++) step(1'b0, 3'd4, $urandom, 8'($urandom), {4{4'(k)}});
        for (int i = 0; i < 2; i++) step_rand(3'd3);
        for (int i = 0; i < 2; i++) step_rand(3'd2);
        for (int i = 0; i < 4; i++) step_rand(3'd1);

        // Long random video stream
        for (int i = 0; i < 10000; i++) step_rand(3'd1);

        // Random legal mode mix
        for (int i = 0; i < 1500; i++) step_rand(3'($urandom_range(0, 4)));

        // Reset mid video stream, then pipeline flush
        for (int i = 0; i < 20; i++) step_rand(3'd1);
        for (int i = 0; i < 3; i++) step(1'b1, 3'd1, $urandom, 8'($urandom), 16'($urandom));
        step_rand(3'd1);
        chk("flush_lane0", 64'(bus.TMDS_O[9:0]), 64'(10'b1101010100));
        for (int i = 0; i < 10; i++) step_rand(3'd1);

        // Illegal mode: CTRL symbol with ERR_O rising on that cycle, sticky until reset
        step(1'b0, 3'd6, $urandom, 8'b0000_0010, 16'($urandom));
        step_rand(3'd1);
        chk("illegal_sym", 64'(bus.TMDS_O[9:0]), 64'(10'b0101010100));
        chk("illegal_err", 64'(bus.ERR_O), 64'd1);
        for (int i = 0; i < 6; i++) step_rand(3'($urandom_range(0, 4)));
        chk("err_sticky", 64'(bus.ERR_O), 64'd1);
        step(1'b1, 3'd0, '0, '0, '0);
        chk("err_cleared", 64'(bus.ERR_O), 64'd0);
        for (int i = 0; i < 4; i++) step_rand(3'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
